// File: rtl/ips2l_pcie_seio_master.sv
// ips2l_pcie_seio_master
// Initiator end of the SEIO sideband serial link. Takes one parallel register
// request at a time, serialises it onto sedo/sedo_en, waits for the responder's
// sedi_ack pulse, shifts back read data on sedi, and returns a one-cycle response.
//
// Ports:
//   pclk_div2   clock
//   user_rst_n  asynchronous active-low reset
//   req_*       request handshake (valid/ready) with wr flag, address, write data
//   rsp_*       one-cycle response strobe with timeout error and read data
//   sedo/sedo_en  serial frame out
//   sedi/sedi_ack serial data and ack pulse from the responder
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | req_ready high, waiting for a request
// SETUP    | sedo_en high, sedo at preamble level L0 (0=write, 1=read)
// START    | one cycle of ~L0; edge direction tells the responder wr/rd
// ADDR     | address bits, MSB first
// DATA     | write data bits, MSB first (writes only)
// STOP     | sedo_en dropped; falling edge closes the frame
// WAIT_ACK | waiting for registered ack, bounded by TIMEOUT cycles
// RDATA    | shifting read data in from registered sedi, MSB first
// RESP     | rsp_valid high for one cycle
module ips2l_pcie_seio_master #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int SETUP_CYC = 2,
    parameter int TIMEOUT   = 255
) (
    input  logic              pclk_div2,
    input  logic              user_rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              sedo,
    output logic              sedo_en,
    input  logic              sedi,
    input  logic              sedi_ack
);

    localparam int MAX_AD = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int MAX_W  = (MAX_AD > SETUP_CYC) ? MAX_AD : SETUP_CYC;
    localparam int CNT_W  = $clog2(MAX_W + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_SETUP, S_START, S_ADDR, S_DATA,
        S_STOP, S_WAIT_ACK, S_RDATA, S_RESP
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [15:0]       tcnt;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_sh;
    logic [DATA_W-1:0] wdata_sh;
    logic [DATA_W-1:0] rd_sh;
    logic [DATA_W-1:0] rd_next;
    logic              ack_r;
    logic              sedi_r;

    assign rd_next = (rd_sh << 1) | DATA_W'(sedi_r);

    always_ff @(posedge pclk_div2 or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            tcnt      <= '0;
            wr_q      <= 1'b0;
            addr_sh   <= '0;
            wdata_sh  <= '0;
            rd_sh     <= '0;
            ack_r     <= 1'b0;
            sedi_r    <= 1'b0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            sedo      <= 1'b0;
            sedo_en   <= 1'b0;
        end else begin
            // Acks outside WAIT_ACK must never leak into the next wait window.
            ack_r  <= sedi_ack && (state == S_WAIT_ACK);
            sedi_r <= sedi;
            case (state)
                S_IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        wr_q      <= req_wr;
                        addr_sh   <= req_addr;
                        wdata_sh  <= req_wdata;
                        req_ready <= 1'b0;
                        sedo_en   <= 1'b1;
                        sedo      <= ~req_wr;
                        cnt       <= '0;
                        state     <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (cnt == CNT_W'(SETUP_CYC - 1)) begin
                        cnt   <= '0;
                        sedo  <= wr_q;
                        state <= S_START;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_START: begin
                    sedo    <= addr_sh[ADDR_W-1];
                    addr_sh <= addr_sh << 1;
                    cnt     <= '0;
                    state   <= S_ADDR;
                end
                S_ADDR: begin
                    if (cnt == CNT_W'(ADDR_W - 1)) begin
                        cnt <= '0;
                        if (wr_q) begin
                            sedo     <= wdata_sh[DATA_W-1];
                            wdata_sh <= wdata_sh << 1;
                            state    <= S_DATA;
                        end else begin
                            sedo    <= 1'b0;
                            sedo_en <= 1'b0;
                            state   <= S_STOP;
                        end
                    end else begin
                        sedo    <= addr_sh[ADDR_W-1];
                        addr_sh <= addr_sh << 1;
                        cnt     <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt == CNT_W'(DATA_W - 1)) begin
                        cnt     <= '0;
                        sedo    <= 1'b0;
                        sedo_en <= 1'b0;
                        state   <= S_STOP;
                    end else begin
                        sedo     <= wdata_sh[DATA_W-1];
                        wdata_sh <= wdata_sh << 1;
                        cnt      <= cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    tcnt  <= '0;
                    cnt   <= '0;
                    state <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    // Ack is checked before the timeout so a coincident ack wins.
                    if (ack_r) begin
                        tcnt  <= '0;
                        cnt   <= '0;
                        rd_sh <= '0;
                        if (wr_q) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                            rsp_rdata <= '0;
                            state     <= S_RESP;
                        end else begin
                            state <= S_RDATA;
                        end
                    end else if (tcnt == 16'(TIMEOUT - 1)) begin
                        tcnt      <= '0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                        state     <= S_RESP;
                    end else begin
                        tcnt <= tcnt + 16'd1;
                    end
                end
                S_RDATA: begin
                    rd_sh <= rd_next;
                    if (cnt == CNT_W'(DATA_W - 1)) begin
                        cnt       <= '0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= rd_next;
                        state     <= S_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ips2l_pcie_seio_master.sv
module tb_ips2l_pcie_seio_master;
    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 8;
    localparam int SETUP_CYC = 2;
    localparam int TIMEOUT   = 255;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_wr = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic              rsp_valid;
    logic              rsp_err;
    logic [DATA_W-1:0] rsp_rdata;
    logic              sedo;
    logic              sedo_en;
    logic              sedi = 1'b0;
    logic              resp_ack = 1'b0;
    logic              stray_ack = 1'b0;
    logic              sedi_ack;
    assign sedi_ack = resp_ack | stray_ack;

    ips2l_pcie_seio_master #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SETUP_CYC(SETUP_CYC), .TIMEOUT(TIMEOUT)
    ) dut (
        .pclk_div2(clk), .user_rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .sedo(sedo), .sedo_en(sedo_en), .sedi(sedi), .sedi_ack(sedi_ack)
    );

    typedef struct { logic [63:0] bits; int len; } frame_t;
    typedef struct { bit err; logic [DATA_W-1:0] rdata; int lat; } rsp_t;
    typedef struct { bit wr; bit no_ack; int delay; logic [DATA_W-1:0] rdv; } job_t;

    frame_t exp_frames[$];
    rsp_t   exp_rsps[$];
    job_t   jobs[$];

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    int rsp_seen = 0;
    int req_cnt = 0;
    int last_stop_cyc = 0;
    event frame_end;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_eq(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: frame = SETUP_CYC x L0, ~L0, address MSB first, data MSB first (writes).
    function automatic frame_t model_frame(bit wr, logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d);
        frame_t f;
        bit l0;
        l0 = ~wr;
        f.bits = '0;
        f.len = 0;
        for (int i = 0; i < SETUP_CYC; i++) begin f.bits = {f.bits[62:0], l0}; f.len++; end
        f.bits = {f.bits[62:0], ~l0}; f.len++;
        for (int i = ADDR_W - 1; i >= 0; i--) begin f.bits = {f.bits[62:0], a[i]}; f.len++; end
        if (wr)
            for (int i = DATA_W - 1; i >= 0; i--) begin f.bits = {f.bits[62:0], d[i]}; f.len++; end
        return f;
    endfunction

    // Latency is counted from the STOP cycle. WAIT_ACK starts the cycle after STOP and
    // lasts at most TIMEOUT cycles; the ack (driven 'delay' cycles after STOP) is seen
    // one cycle later through the internal register.
    function automatic rsp_t model_rsp(bit wr, bit no_ack, int delay, logic [DATA_W-1:0] rdv);
        rsp_t r;
        if (no_ack || (delay + 1 > TIMEOUT)) begin
            r.err = 1'b1; r.rdata = '0; r.lat = TIMEOUT + 1;
        end else if (wr) begin
            r.err = 1'b0; r.rdata = '0; r.lat = delay + 2;
        end else begin
            r.err = 1'b0; r.rdata = rdv; r.lat = delay + 2 + DATA_W;
        end
        return r;
    endfunction

    // Frame monitor: captures sedo while sedo_en is high, compares on the STOP cycle.
    initial begin : frame_mon
        frame_t cap;
        frame_t f;
        bit prev_en;
        bit idle_bad;
        cap.bits = '0; cap.len = 0; prev_en = 0; idle_bad = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cap.bits = '0; cap.len = 0; prev_en = 0; idle_bad = 0;
            end else begin
                if (sedo_en) begin
                    cap.bits = {cap.bits[62:0], sedo};
                    cap.len++;
                end else begin
                    if (sedo) idle_bad = 1;
                    if (prev_en) begin
                        last_stop_cyc = cyc;
                        chk_eq("frame_expected", longint'(exp_frames.size() > 0), 1);
                        if (exp_frames.size() > 0) begin
                            f = exp_frames.pop_front();
                            chk_eq("frame_len", cap.len, f.len);
                            chk_eq("frame_bits", cap.bits, f.bits);
                            chk_eq("sedo_low_outside_frame", idle_bad, 0);
                        end
                        cap.bits = '0; cap.len = 0; idle_bad = 0;
                        -> frame_end;
                    end
                end
                prev_en = sedo_en;
            end
        end
    end

    // Responder model: ack 'delay' cycles after STOP, then read bits MSB first.
    initial begin : responder
        job_t j;
        forever begin
            @(frame_end);
            if (jobs.size() > 0) begin
                j = jobs.pop_front();
                if (!j.no_ack) begin
                    repeat (j.delay) @(posedge clk);
                    #1 resp_ack = 1'b1;
                    @(posedge clk);
                    #1 resp_ack = 1'b0;
                    if (!j.wr) begin
                        for (int i = DATA_W - 1; i >= 0; i--) begin
                            sedi = j.rdv[i];
                            @(posedge clk);
                            #1;
                        end
                        sedi = 1'b0;
                    end
                end
            end
        end
    end

    // Response monitor / scoreboard.
    initial begin : rsp_mon
        rsp_t r;
        bit after;
        after = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                after = 0;
            end else begin
                if (after) begin
                    chk_eq("rsp_valid_one_cycle", rsp_valid, 0);
                    chk_eq("ready_after_resp", req_ready, 1);
                    after = 0;
                end
                if (rsp_valid) begin
                    rsp_seen++;
                    after = 1;
                    chk_eq("rsp_expected", longint'(exp_rsps.size() > 0), 1);
                    if (exp_rsps.size() > 0) begin
                        r = exp_rsps.pop_front();
                        chk_eq("rsp_err", rsp_err, r.err);
                        chk_eq("rsp_rdata", rsp_rdata, r.rdata);
                        chk_eq("rsp_latency", cyc - last_stop_cyc, r.lat);
                    end
                end
            end
        end
    end

    task automatic do_req(input bit wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          input bit no_ack, input int delay, input logic [DATA_W-1:0] rdv,
                          input int hold, input bit stray_data);
        bit ok;
        job_t j;
        @(posedge clk);
        #1;
        req_wr = wr; req_addr = a; req_wdata = d; req_valid = 1'b1;
        ok = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1; break; end
        end
        chk_eq("req_accepted", ok, 1);
        if (!ok) begin
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        exp_frames.push_back(model_frame(wr, a, d));
        exp_rsps.push_back(model_rsp(wr, no_ack, delay, rdv));
        j.wr = wr; j.no_ack = no_ack; j.delay = delay; j.rdv = rdv;
        jobs.push_back(j);
        req_cnt++;
        #1;
        // k = cycles since accept; write DATA occupies offsets 12..19.
        for (int k = 1; k <= 20; k++) begin
            req_valid = (k <= hold);
            if (k <= hold) begin
                req_addr = ADDR_W'($urandom);
                req_wdata = DATA_W'($urandom);
                req_wr = 1'($urandom);
            end
            stray_ack = stray_data && (k == 14);
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        stray_ack = 1'b0;
        ok = 0;
        for (int k = 0; k < 2000; k++) begin
            if (rsp_seen >= req_cnt) begin ok = 1; break; end
            @(negedge clk);
        end
        chk_eq("rsp_arrived", ok, 1);
    endtask

    initial begin : main
        int saved;
        #12;
        chk_eq("reset_sedo", sedo, 0);
        chk_eq("reset_sedo_en", sedo_en, 0);
        chk_eq("reset_req_ready", req_ready, 0);
        chk_eq("reset_rsp_valid", rsp_valid, 0);
        chk_eq("reset_rsp_err", rsp_err, 0);
        chk_eq("reset_rsp_rdata", rsp_rdata, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_eq("idle_req_ready", req_ready, 1);

        do_req(1'b1, 8'hA5, 8'h3C, 1'b0, 2, 8'h00, 0, 1'b0);
        do_req(1'b0, 8'h12, 8'h00, 1'b0, 2, 8'h96, 0, 1'b0);
        do_req(1'b0, 8'h5A, 8'h00, 1'b0, 1, 8'h00, 0, 1'b0);
        do_req(1'b1, 8'h33, 8'hC3, 1'b1, 0, 8'h00, 0, 1'b0);
        do_req(1'b0, 8'h81, 8'h00, 1'b0, 3, 8'hE7, 0, 1'b0);
        do_req(1'b0, 8'h7E, 8'h00, 1'b0, TIMEOUT - 1, 8'h5B, 0, 1'b0);

        // Stray ack while idle, then a held-valid write with a stray ack inside DATA.
        saved = rsp_seen;
        @(posedge clk);
        #1 stray_ack = 1'b1;
        @(posedge clk);
        #1 stray_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk_eq("stray_idle_ready", req_ready, 1);
        chk_eq("stray_idle_sedo_en", sedo_en, 0);
        chk_eq("stray_idle_no_rsp", rsp_seen, saved);
        do_req(1'b1, 8'hF0, 8'h0F, 1'b0, 4, 8'h00, 6, 1'b1);

        // Reset in the middle of ADDR aborts without a response.
        saved = rsp_seen;
        @(posedge clk);
        #1 req_wr = 1'b1; req_addr = 8'hC6; req_wdata = 8'h9A; req_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (req_ready) break;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk_eq("abort_sedo", sedo, 0);
        chk_eq("abort_sedo_en", sedo_en, 0);
        chk_eq("abort_req_ready", req_ready, 0);
        chk_eq("abort_rsp_valid", rsp_valid, 0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_eq("abort_ready_after_release", req_ready, 1);
        chk_eq("abort_no_rsp", rsp_seen, saved);
        do_req(1'b1, 8'h69, 8'h96, 1'b0, 2, 8'h00, 0, 1'b0);

        for (int n = 0; n < 24; n++) begin
            bit wr;
            wr = 1'($urandom);
            do_req(wr, ADDR_W'($urandom), DATA_W'($urandom),
                   ($urandom_range(0, 7) == 0), $urandom_range(1, 6), DATA_W'($urandom),
                   $urandom_range(0, 3), wr && ($urandom_range(0, 1) == 1));
        end

        repeat (10) @(negedge clk);
        chk_eq("frames_drained", exp_frames.size(), 0);
        chk_eq("rsps_drained", exp_rsps.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
